onehot_decoder_buf: RTL

//  Inverse of the 4-to-2 priority encoder: takes a binary line index and produces a one-hot line select.

---
 rtl/prio_dec_pkg.sv | 20 ++
 rtl/idx_fifo.sv | 64 ++++++
 rtl/onehot_decoder_buf.sv | 74 +++++++
 3 files changed

// File: rtl/prio_dec_pkg.sv
// Shared types and helpers for the one-hot decoder buffer.
// Holds the FIFO occupancy state, the hit counter width and the one-hot helper.
package prio_dec_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      PARTIAL,
      FULL
   } dec_state_e;

   localparam int HIT_CNT_W = 8;

   // Widest one-hot word the helper can build; callers cast down to OUT_W.
   localparam int MAX_OUT_W = 256;

   function automatic logic [MAX_OUT_W-1:0] onehot_f(input int unsigned idx);
      return MAX_OUT_W'(1) << idx;
   endfunction

endpackage

// File: rtl/idx_fifo.sv
// Index FIFO: storage, wrapping pointers, occupancy count and derived state.
// Ports: clk, rst (sync, active-high), push/din write, pop/dout head, state.
module idx_fifo
   import prio_dec_pkg::*;
#(
   parameter int IDX_W = 2,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [IDX_W-1:0] din,
   input  logic             pop,
   output logic [IDX_W-1:0] dout,
   output dec_state_e       state
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [IDX_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   // Storage is left unreset; count gates every read of it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state = PARTIAL;
      if (count == '0) begin
         state = EMPTY;
      end else if (count == CNT_W'(DEPTH)) begin
         state = FULL;
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/onehot_decoder_buf.sv
// Buffered binary-to-one-hot line decoder with valid/ready streams.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_idx input stream;
// out_valid/out_ready/out_onehot output stream; hit_clr, hit_cnt per-line
// pop counters, present only when PRIO_DEC_HIT_CNT_EN is defined.
module onehot_decoder_buf
   import prio_dec_pkg::*;
#(
   parameter int IDX_W = 2,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IDX_W-1:0]           in_idx,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [(1<<IDX_W)-1:0]      out_onehot,
   input  logic                       hit_clr,
   output logic [(1<<IDX_W)*8-1:0]    hit_cnt
);

   localparam int OUT_W = 1 << IDX_W;

   logic             push;
   logic             pop;
   logic [IDX_W-1:0] head;
   dec_state_e       state;

   // No bypass: a full FIFO refuses input even if it pops this cycle.
   assign in_ready  = !rst && (state != FULL);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   idx_fifo #(
      .IDX_W (IDX_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (in_idx),
      .pop   (pop),
      .dout  (head),
      .state (state)
   );

   assign out_onehot = out_valid ? OUT_W'(onehot_f(32'(head))) : '0;

`ifdef PRIO_DEC_HIT_CNT_EN
   logic [HIT_CNT_W-1:0] cnt [OUT_W];

   // Clear wins over a same-cycle increment; counters saturate.
   always_ff @(posedge clk) begin
      for (int i = 0; i < OUT_W; i++) begin
         if (rst || hit_clr) begin
            cnt[i] <= '0;
         end else if (pop && head == IDX_W'(i) && cnt[i] != '1) begin
            cnt[i] <= cnt[i] + HIT_CNT_W'(1);
         end
      end
   end

   for (genvar g = 0; g < OUT_W; g++) begin : g_hit
      assign hit_cnt[HIT_CNT_W*g +: HIT_CNT_W] = cnt[g];
   end
`else
   logic unused_hit_clr;
   assign unused_hit_clr = hit_clr;
   assign hit_cnt        = '0;
`endif

endmodule
